// File: rtl/mem_split_ctrl.sv
// Memory-access sequencer: turns one load/store into one or two word-aligned
// beats with byte enables, stalling upstream and flagging split loads.
module mem_split_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [4:0]  opcode,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall,
  output logic        is_misaligned
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      state, state_next;
  logic [4:0]  op_q;
  logic        store_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        mem_op;
  logic        is_word, is_half;
  logic [1:0]  off;
  logic        split;
  logic        final_beat;
  logic [31:0] base;
  logic [31:0] data_m;
  logic [4:0]  sh0;
  logic [5:0]  sh1;
  logic [2:0]  rs;
  logic [3:0]  be0, be1;
  logic [31:0] data0, data1;

  assign mem_op  = op_valid & (is_load | is_store) & (opcode >= 5'd3) & (opcode <= 5'd11);

  // Beat fields depend only on the captured operation, never on live inputs.
  assign is_word = (op_q >= 5'd3) & (op_q <= 5'd5);
  assign is_half = (op_q >= 5'd6) & (op_q <= 5'd8);
  assign off     = addr_q[1:0];
  assign split   = (is_word & (off != 2'd0)) | (is_half & (off == 2'd3));
  assign base    = {addr_q[31:2], 2'b00};
  assign data_m  = is_word ? wdata_q :
                   is_half ? {16'h0, wdata_q[15:0]} : {24'h0, wdata_q[7:0]};
  assign sh0     = {off, 3'b000};
  assign sh1     = 6'd32 - {1'b0, off, 3'b000};
  assign rs      = 3'd4 - {1'b0, off};
  assign be0     = is_word ? (4'b1111 << off) :
                   is_half ? (4'b0011 << off) : (4'b0001 << off);
  assign be1     = is_word ? (4'b1111 >> rs) : 4'b0001;
  assign data0   = data_m << sh0;
  assign data1   = data_m >> sh1;

  assign final_beat = (state == BEAT1) | ((state == BEAT0) & !split);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      store_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_misaligned <= 1'b0;
    end else begin
      state         <= state_next;
      is_misaligned <= (state == BEAT1) & mem_ready & !store_q;
      if ((state == IDLE) && mem_op) begin
        op_q    <= opcode;
        store_q <= is_store;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    unique case (state)
      IDLE: begin
        if (mem_op) state_next = BEAT0;
      end
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = base;
        mem_be    = store_q ? be0 : 4'b1111;
        mem_wdata = store_q ? data0 : 32'h0;
        if (mem_ready) state_next = split ? BEAT1 : IDLE;
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = base + 32'd4;
        mem_be    = store_q ? be1 : 4'b1111;
        mem_wdata = store_q ? data1 : 32'h0;
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The completion cycle of the final beat releases the pipeline.
  assign stall = ((state == IDLE) & mem_op) |
                 ((state != IDLE) & !(final_beat & mem_ready));

endmodule

// File: tb/tb_mem_split_ctrl.sv
// Directed bench for mem_split_ctrl: a vector table for single/split ops with
// mem_ready held high, plus sequences for backpressure, non-memory ops and reset.
module tb_mem_split_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [4:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        stall;
  logic        is_misaligned;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_split_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .opcode(opcode),
    .is_load(is_load), .is_store(is_store), .addr(addr), .wdata(wdata),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .stall(stall), .is_misaligned(is_misaligned)
  );

  typedef struct {
    logic [4:0]  opcode;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          beats;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic [31:0] data0;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] data1;
    logic        mis;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] opc, input logic ld,
                                input logic st, input logic [31:0] a, input logic [31:0] d);
    op_valid = v;
    opcode   = opc;
    is_load  = ld;
    is_store = st;
    addr     = a;
    wdata    = d;
  endtask

  task automatic check_beat(input string tag, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d, input logic st);
    check_output({tag, " req"},   32'(mem_req), 32'd1);
    check_output({tag, " we"},    32'(mem_we), 32'(we));
    check_output({tag, " addr"},  mem_addr, a);
    check_output({tag, " be"},    32'(mem_be), 32'(be));
    check_output({tag, " wdata"}, mem_wdata, d);
    check_output({tag, " stall"}, 32'(stall), 32'(st));
    check_output({tag, " mis"},   32'(is_misaligned), 32'd0);
  endtask

  initial begin
    int stall_cnt;
    vecs[0]  = '{5'd3,  1'b0, 32'h00000100, 32'h0,        1, 32'h00000100, 4'b1111, 32'h0,        32'h0,        4'b0,    32'h0,        1'b0};
    vecs[1]  = '{5'd4,  1'b1, 32'h00000203, 32'hAABBCCDD, 2, 32'h00000200, 4'b1000, 32'hDD000000, 32'h00000204, 4'b0111, 32'h00AABBCC, 1'b0};
    vecs[2]  = '{5'd5,  1'b0, 32'hFFFFFFFE, 32'h0,        2, 32'hFFFFFFFC, 4'b1111, 32'h0,        32'h00000000, 4'b1111, 32'h0,        1'b1};
    vecs[3]  = '{5'd9,  1'b1, 32'h00000012, 32'h0000005A, 1, 32'h00000010, 4'b0100, 32'h005A0000, 32'h0,        4'b0,    32'h0,        1'b0};
    vecs[4]  = '{5'd6,  1'b1, 32'h00000021, 32'h00001234, 1, 32'h00000020, 4'b0110, 32'h00123400, 32'h0,        4'b0,    32'h0,        1'b0};
    vecs[5]  = '{5'd7,  1'b1, 32'h00000033, 32'h0000BEEF, 2, 32'h00000030, 4'b1000, 32'hEF000000, 32'h00000034, 4'b0001, 32'h000000BE, 1'b0};
    vecs[6]  = '{5'd3,  1'b1, 32'h00000042, 32'h11223344, 2, 32'h00000040, 4'b1100, 32'h33440000, 32'h00000044, 4'b0011, 32'h00001122, 1'b0};
    vecs[7]  = '{5'd5,  1'b1, 32'h00000080, 32'hCAFEF00D, 1, 32'h00000080, 4'b1111, 32'hCAFEF00D, 32'h0,        4'b0,    32'h0,        1'b0};
    vecs[8]  = '{5'd8,  1'b0, 32'h00000002, 32'h0,        1, 32'h00000000, 4'b1111, 32'h0,        32'h0,        4'b0,    32'h0,        1'b0};
    vecs[9]  = '{5'd11, 1'b1, 32'h00000007, 32'hFFFFFF99, 1, 32'h00000004, 4'b1000, 32'h99000000, 32'h0,        4'b0,    32'h0,        1'b0};
    vecs[10] = '{5'd3,  1'b1, 32'h00000001, 32'h87654321, 2, 32'h00000000, 4'b1110, 32'h65432100, 32'h00000004, 4'b0001, 32'h00000087, 1'b0};

    rst_n = 1'b0;
    mem_ready = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check_output("reset req",   32'(mem_req), 32'd0);
    check_output("reset we",    32'(mem_we), 32'd0);
    check_output("reset addr",  mem_addr, 32'h0);
    check_output("reset wdata", mem_wdata, 32'h0);
    check_output("reset be",    32'(mem_be), 32'd0);
    check_output("reset stall", 32'(stall), 32'd0);
    check_output("reset mis",   32'(is_misaligned), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      apply_stimulus(1'b1, vecs[i].opcode, !vecs[i].store, vecs[i].store, vecs[i].addr, vecs[i].wdata);
      #1;
      check_output($sformatf("v%0d idle stall", i), 32'(stall), 32'd1);
      check_output($sformatf("v%0d idle req", i), 32'(mem_req), 32'd0);
      @(negedge clk);
      apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_beat($sformatf("v%0d b0", i), vecs[i].store, vecs[i].addr0, vecs[i].be0,
                 vecs[i].data0, vecs[i].beats == 2);
      if (vecs[i].beats == 2) begin
        @(negedge clk);
        #1;
        check_beat($sformatf("v%0d b1", i), vecs[i].store, vecs[i].addr1, vecs[i].be1,
                   vecs[i].data1, 1'b0);
      end
      @(negedge clk);
      #1;
      check_output($sformatf("v%0d done req", i), 32'(mem_req), 32'd0);
      check_output($sformatf("v%0d done mis", i), 32'(is_misaligned), 32'(vecs[i].mis));
      check_output($sformatf("v%0d done stall", i), 32'(stall), 32'd0);
    end

    // Split halfword load with three wait cycles per beat.
    @(negedge clk);
    stall_cnt = 0;
    mem_ready = 1'b0;
    apply_stimulus(1'b1, 5'd6, 1'b1, 1'b0, 32'h00000007, 32'h0);
    #1;
    stall_cnt += int'(stall);
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        apply_stimulus(1'b1, 5'd3, 1'b0, 1'b1, 32'h0000DEAD, 32'hFFFFFFFF);
        mem_ready = (w == 3);
        #1;
        stall_cnt += int'(stall);
        check_beat($sformatf("bp b%0d w%0d", b, w), 1'b0, (b == 0) ? 32'h4 : 32'h8,
                   4'b1111, 32'h0, !((b == 1) && (w == 3)));
      end
    end
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("bp stall count", 32'(stall_cnt), 32'd8);
    check_output("bp mis pulse", 32'(is_misaligned), 32'd1);
    @(negedge clk);
    #1;
    check_output("bp mis clear", 32'(is_misaligned), 32'd0);
    check_output("bp idle req", 32'(mem_req), 32'd0);

    // Non-memory operations are ignored.
    mem_ready = 1'b1;
    apply_stimulus(1'b1, 5'd12, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check_output("nonmem12 stall", 32'(stall), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd3, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    check_output("nonmem12 req", 32'(mem_req), 32'd0);
    check_output("noloadstore stall", 32'(stall), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd2, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check_output("noloadstore req", 32'(mem_req), 32'd0);
    check_output("nonmem2 stall", 32'(stall), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("nonmem2 req", 32'(mem_req), 32'd0);

    // Reset asserted in the middle of BEAT1 of a split store.
    @(negedge clk);
    apply_stimulus(1'b1, 5'd4, 1'b0, 1'b1, 32'h00000203, 32'hAABBCCDD);
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check_output("rst pre addr", mem_addr, 32'h00000204);
    rst_n = 1'b0;
    #1;
    check_output("rst mid req",   32'(mem_req), 32'd0);
    check_output("rst mid addr",  mem_addr, 32'h0);
    check_output("rst mid be",    32'(mem_be), 32'd0);
    check_output("rst mid wdata", mem_wdata, 32'h0);
    check_output("rst mid stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("rst after req c%0d", c), 32'(mem_req), 32'd0);
      check_output($sformatf("rst after mis c%0d", c), 32'(is_misaligned), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
